ecg_raw_filt_aligner: RTL

Sits beside the ADC-to-IIR link in the ECG chain. It taps raw samples at the ADC→IIR AXIS handshake and buffers them in a FIFO until the matching IIR output arrives. It then emits raw, filtered, interleaved, or raw-minus-filtered records on one AXIS master. This replaces the static raw/filtered output mux with a sample-aligned, runtime-selectable stream suitable for UART/logic-analyser capture.

---
 rtl/ecg_align_pkg.sv | 36 +++
 rtl/ecg_raw_filt_aligner_fifo.sv | 61 ++++++
 rtl/ecg_raw_filt_aligner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ecg_align_pkg.sv
// ecg_align_pkg: shared encodings for the raw/filtered aligner.
// Record modes, FSM states and the raw-minus-filtered clamp.
package ecg_align_pkg;

    localparam logic [1:0] MODE_FILT = 2'd0;
    localparam logic [1:0] MODE_RAW  = 2'd1;
    localparam logic [1:0] MODE_ILV  = 2'd2;
    localparam logic [1:0] MODE_DIFF = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_EMIT_FILT = 1'b1
    } state_t;

    // a - b clamped to the signed range of a w-bit word (w <= 30)
    function automatic logic signed [31:0] sat_sub(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [31:0] d;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        d  = a - b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (d > hi) begin
            return hi;
        end
        if (d < lo) begin
            return lo;
        end
        return d;
    endfunction

endpackage

// File: rtl/ecg_raw_filt_aligner_fifo.sv
// ecg_sample_fifo: raw-sample FIFO for the aligner.
// Registered occupancy; push at full is accepted only with a pop.
module ecg_sample_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DW-1:0]    din,
    input  logic             pop,
    output logic [DW-1:0]    dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr];

    // storage array, written at the tail
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                level <= level + LVL_W'(1);
            end else if (!wr_en && rd_en) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/ecg_raw_filt_aligner.sv
// ecg_raw_filt_aligner: pairs tapped raw ADC samples with IIR outputs
// and emits raw/filt/interleaved/diff records. Option: ALIGN_SEQ_NUM_EN.
module ecg_raw_filt_aligner
    import ecg_align_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    raw_tdata,
    input  logic             raw_tvalid,
    input  logic             raw_tready,
    input  logic [DW-1:0]    filt_tdata,
    input  logic             filt_tvalid,
    output logic             filt_tready,
    input  logic [1:0]       mode,
    input  logic             clr_flags,
    output logic [DW-1:0]    m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             overflow,
    output logic             underflow,
    output logic [LVL_W-1:0] fifo_level
`ifdef ALIGN_SEQ_NUM_EN
    ,
    output logic [15:0]      m_axis_tuser
`endif
);

    state_t        state_q;
    state_t        state_d;
    logic          rdy_q;
    logic          raw_push;
    logic          fire_f;
    logic          fire_m;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head;
    logic [DW-1:0] raw_part;
    logic [DW-1:0] diff_d;
    logic [DW-1:0] filt_q;
    logic          load_rec;
    logic          load_filt;
    logic          ovf_set;
    logic          udf_set;

    assign raw_push = raw_tvalid & raw_tready;
    assign fire_f   = filt_tvalid & filt_tready;
    assign fire_m   = m_axis_tvalid & m_axis_tready;
    assign pop      = fire_f & ~fifo_empty;
    assign push     = raw_push & (~fifo_full | pop);
    assign raw_part = fifo_empty ? '0 : fifo_head;
    assign ovf_set  = raw_push & fifo_full & ~pop;
    assign udf_set  = fire_f & fifo_empty;
    assign diff_d   = DW'(sat_sub(32'(signed'(raw_part)),
                                  32'(signed'(filt_tdata)), DW));

    ecg_sample_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (raw_tdata),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // holds filt_tready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // EMIT_FILT spans the raw beat of an interleaved record
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fire_f && mode == MODE_ILV) begin
                    state_d = ST_EMIT_FILT;
                end
            end
            ST_EMIT_FILT: begin
                if (fire_m) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: IIR ready and output-register load strobes
    always_comb begin
        filt_tready = rdy_q & (state_q == ST_IDLE)
                    & (~m_axis_tvalid | m_axis_tready);
        load_rec    = fire_f;
        load_filt   = (state_q == ST_EMIT_FILT) & fire_m;
    end

    // output register: new record, second interleaved beat, or drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            filt_q        <= '0;
        end else if (load_rec) begin
            m_axis_tvalid <= 1'b1;
            filt_q        <= filt_tdata;
            unique case (mode)
                MODE_FILT: begin
                    m_axis_tdata <= filt_tdata;
                    m_axis_tlast <= 1'b1;
                end
                MODE_RAW: begin
                    m_axis_tdata <= raw_part;
                    m_axis_tlast <= 1'b1;
                end
                MODE_ILV: begin
                    m_axis_tdata <= raw_part;
                    m_axis_tlast <= 1'b0;
                end
                MODE_DIFF: begin
                    m_axis_tdata <= diff_d;
                    m_axis_tlast <= 1'b1;
                end
            endcase
        end else if (load_filt) begin
            m_axis_tdata <= filt_q;
            m_axis_tlast <= 1'b1;
        end else if (fire_m) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // sticky flags; a set in the same cycle beats clr_flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow & ~clr_flags);
            underflow <= udf_set | (underflow & ~clr_flags);
        end
    end

`ifdef ALIGN_SEQ_NUM_EN
    logic [15:0] seq_q;

    assign m_axis_tuser = seq_q;

    // record counter, advances when a tlast beat is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else if (fire_m && m_axis_tlast) begin
            seq_q <= seq_q + 16'd1;
        end
    end
`endif

endmodule
